// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int PC_W = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: pc register, BOOT/FETCH/HOLD control, one-cycle fetch latency.
// Optional redirect alignment checking is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              MEM_SIZE = 256
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_stall,
  input  logic [31:0]     imem_data,
  output logic [31:0]     if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic            if_valid,
  output logic            fetch_err
);

  localparam logic [PC_W:0] MEM_BYTES = (PC_W+1)'(MEM_SIZE) << 2;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] issued_pc;
  logic            issued_q;
  logic            fetch_err_q;

  logic            out_of_range;
  logic            issue_slot;
  logic            issued;
  logic            misaligned;
  logic [PC_W-1:0] redirect_target;

  assign out_of_range = {1'b0, pc} >= MEM_BYTES;
  assign issue_slot   = (state == FETCH) && !stall && !redirect_valid;
  assign issued       = issue_slot && !out_of_range;

  // An out-of-range slot is squashed like a redirect, so memory is told to emit a NOP too.
  assign imem_stall   = !reset_n || !issued;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned      = redirect_pc[1:0] != 2'b00;
  assign redirect_target = redirect_pc;
`else
  assign misaligned      = 1'b0;
  assign redirect_target = {redirect_pc[PC_W-1:2], 2'b00};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      issued_pc   <= RESET_PC;
      issued_q    <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      issued_pc <= pc;
      issued_q  <= issued;
      if (issue_slot && out_of_range)
        fetch_err_q <= 1'b1;

      // Redirect outranks stall; a rejected misaligned target keeps the current pc.
      if (state == BOOT) begin
        state <= FETCH;
      end else if (redirect_valid) begin
        if (misaligned)
          fetch_err_q <= 1'b1;
        else
          pc <= redirect_target;
        state <= stall ? HOLD : FETCH;
      end else begin
        case (state)
          FETCH: begin
            if (stall)
              state <= HOLD;
            else
              pc <= pc + 32'd4;
          end
          HOLD: begin
            if (!stall)
              state <= FETCH;
          end
          default: state <= BOOT;
        endcase
      end
    end
  end

  assign imem_addr = pc;
  assign if_instr  = imem_data;
  assign if_pc     = issued_pc;
  assign if_valid  = issued_q;
  assign fetch_err = fetch_err_q;

endmodule
